// File: rtl/updown_pulse_tx_if.sv
// Request and pulse-line bundle for the UP/DOWN pulse transmitter.
// The master drives step requests; the slave (the transmitter) drives the lines and status.
interface updown_pulse_tx_if #(
  parameter int COUNT_W = 8
) ();
  logic               req_valid;
  logic               req_dir;
  logic [COUNT_W-1:0] req_count;
  logic               req_ready;
  logic               up;
  logic               down;
  logic               busy;
  logic [COUNT_W-1:0] remaining;
  logic               done;

  modport master (
    output req_valid, req_dir, req_count,
    input  req_ready, up, down, busy, remaining, done
  );

  modport slave (
    input  req_valid, req_dir, req_count,
    output req_ready, up, down, busy, remaining, done
  );
endinterface

// File: rtl/updown_pulse_tx.sv
// Transmit end of the UP/DOWN pulse channel: turns a (direction, count) request into a pulse train.
// Optional macro UPDOWN_PULSE_TX_ABORT_EN adds an abort input that ends a train early.
module updown_pulse_tx #(
  parameter int COUNT_W = 8,
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef UPDOWN_PULSE_TX_ABORT_EN
  input  logic abort,
`endif
  updown_pulse_tx_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Timer reloads hold the number of cycles left after the current one.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_W - 1);

  logic [1:0]         state, state_nxt;
  logic [7:0]         timer, timer_nxt;
  logic [COUNT_W-1:0] remaining, remaining_nxt;
  logic               dir, dir_nxt;
  logic               up_q, down_q;
  logic               abort_req;

`ifdef UPDOWN_PULSE_TX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt     = state;
    timer_nxt     = timer;
    remaining_nxt = remaining;
    dir_nxt       = dir;

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          dir_nxt       = bus.req_dir;
          remaining_nxt = bus.req_count;
          if (bus.req_count == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_PULSE;
            timer_nxt = PULSE_LOAD;
          end
        end
      end

      S_PULSE: begin
        if (abort_req) begin
          // A pulse cut short is not counted; remaining holds.
          state_nxt = S_DONE;
        end else if (timer != 8'd0) begin
          timer_nxt = timer - 8'd1;
        end else begin
          if (remaining != '0) begin
            remaining_nxt = remaining - 1'b1;
          end
          if (remaining <= COUNT_W'(1)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_GAP;
            timer_nxt = GAP_LOAD;
          end
        end
      end

      S_GAP: begin
        if (abort_req) begin
          state_nxt = S_DONE;
        end else if (timer != 8'd0) begin
          timer_nxt = timer - 8'd1;
        end else begin
          state_nxt = S_PULSE;
          timer_nxt = PULSE_LOAD;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= 8'd0;
      remaining <= '0;
      dir       <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state     <= state_nxt;
      timer     <= timer_nxt;
      remaining <= remaining_nxt;
      dir       <= dir_nxt;
      // Lines are decoded from the next state so they come straight off flops.
      up_q      <= (state_nxt == S_PULSE) && !dir_nxt;
      down_q    <= (state_nxt == S_PULSE) &&  dir_nxt;
    end
  end

  assign bus.up        = up_q;
  assign bus.down      = down_q;
  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.remaining = remaining;

endmodule

// File: tb/tb_updown_pulse_tx.sv
// Self-checking bench for updown_pulse_tx: closed-form train model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.
module tb_updown_pulse_tx;

  localparam int COUNT_W = 8;
  localparam int P       = 4;
  localparam int G       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort_s = 1'b0;

  always #5 clk = ~clk;

  updown_pulse_tx_if #(.COUNT_W(COUNT_W)) bus ();

  updown_pulse_tx #(
    .COUNT_W(COUNT_W),
    .PULSE_W(P),
    .GAP_W  (G)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef UPDOWN_PULSE_TX_ABORT_EN
    .abort(abort_s),
`endif
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A train accepted at an edge is described by offset k (k = 1 is the cycle
  // after acceptance). Pulse j occupies k in [j*(P+G)+1, j*(P+G)+P].
  typedef struct packed {
    logic        up;
    logic        down;
    logic        done;
    logic        busy;
    logic        ready;
    logic [31:0] rem;
  } out_t;

  bit m_active    = 1'b0;
  bit m_dir       = 1'b0;
  int m_k         = 0;
  int m_n         = 0;
  int m_done_k    = 0;
  int m_rem_final = 0;
  bit chk_en      = 1'b0;

  function automatic out_t model_at(input int k);
    out_t o;
    int   j;
    int   ph;
    bit   in_p;
    o.up = 1'b0; o.down = 1'b0; o.done = 1'b0;
    o.busy = 1'b0; o.ready = 1'b1; o.rem = 32'd0;
    if (!m_active) begin
      o.rem = 32'd0;
    end else if (k > m_done_k) begin
      o.rem = 32'(m_rem_final);
    end else if (k == m_done_k) begin
      o.done = 1'b1; o.busy = 1'b1; o.ready = 1'b0;
      o.rem  = 32'(m_rem_final);
    end else begin
      j    = (k - 1) / (P + G);
      ph   = (k - 1) % (P + G);
      in_p = (ph < P);
      o.busy  = 1'b1;
      o.ready = 1'b0;
      o.up    = in_p && !m_dir;
      o.down  = in_p &&  m_dir;
      o.rem   = 32'(m_n - j - (in_p ? 0 : 1));
    end
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active    = 1'b0;
      m_k         = 0;
      m_rem_final = 0;
    end else if (!m_active || m_k > m_done_k) begin
      if (bus.req_valid) begin
        m_active    = 1'b1;
        m_k         = 1;
        m_n         = int'(bus.req_count);
        m_dir       = bus.req_dir;
        m_done_k    = (m_n == 0) ? 1 : m_n * P + (m_n - 1) * G + 1;
        m_rem_final = 0;
      end
    end else if (m_k < m_done_k && abort_s) begin
      m_rem_final = int'(model_at(m_k).rem);
      m_done_k    = m_k + 1;
      m_k         = m_k + 1;
    end else begin
      m_k = m_k + 1;
    end
  end

  always @(negedge clk) begin : cmp
    out_t e;
    if (chk_en && !rst) begin
      e = model_at(m_k);
      check_bit("cyc_up",    bus.up,        e.up);
      check_bit("cyc_down",  bus.down,      e.down);
      check_bit("cyc_done",  bus.done,      e.done);
      check_bit("cyc_busy",  bus.busy,      e.busy);
      check_bit("cyc_ready", bus.req_ready, e.ready);
      check_val("cyc_rem",   int'(bus.remaining), int'(e.rem));
      check_bit("cyc_excl",  bus.up && bus.down, 1'b0);
    end
  end

  // ---------------- directed capture ----------------
  logic c_up   [0:40];
  logic c_dn   [0:40];
  logic c_done [0:40];
  logic c_busy [0:40];
  logic c_rdy  [0:40];
  int   c_rem  [0:40];

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      if (!m_active || m_k > m_done_k) return;
      @(posedge clk); #2;
    end
    check_bit("idle_timeout", bus.req_ready, 1'b1);
  endtask

  // Called 2 time units after a rising edge; returns at the same phase.
  task automatic run_req(input logic dir, input int cnt, input int ncyc,
                         input bit hold_valid, input int new_at, input int new_cnt,
                         input int abort_at);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_dir   = dir;
    bus.req_count = COUNT_W'(cnt);
    @(posedge clk); #2;
    if (!hold_valid) bus.req_valid = 1'b0;
    c_up[0] = 1'b0; c_dn[0] = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == new_at) bus.req_count = COUNT_W'(new_cnt);
      if (k == abort_at) abort_s = 1'b1;
      @(negedge clk);
      c_up[k]   = bus.up;
      c_dn[k]   = bus.down;
      c_done[k] = bus.done;
      c_busy[k] = bus.busy;
      c_rdy[k]  = bus.req_ready;
      c_rem[k]  = int'(bus.remaining);
      @(posedge clk); #2;
      abort_s = 1'b0;
    end
    bus.req_valid = 1'b0;
  endtask

  function automatic int rises(input bit use_dn, input int last);
    int n = 0;
    for (int k = 1; k <= last; k++) begin
      if (use_dn ? (c_dn[k] && !c_dn[k-1]) : (c_up[k] && !c_up[k-1])) n++;
    end
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int any_dn;
    int up_hi, dn_hi, up_r, dn_r, done_at, bad_up;
    bit prev;
    bus.req_valid = 1'b0;
    bus.req_dir   = 1'b0;
    bus.req_count = '0;

    // Reset
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_bit("rst_up",    bus.up,        1'b0);
    check_bit("rst_down",  bus.down,      1'b0);
    check_bit("rst_done",  bus.done,      1'b0);
    check_bit("rst_busy",  bus.busy,      1'b0);
    check_bit("rst_ready", bus.req_ready, 1'b1);
    check_val("rst_rem",   int'(bus.remaining), 0);
    chk_en = 1'b1;
    @(posedge clk); #2;

    // UP x3: pulses at 1-4, 9-12, 17-20; DONE at 21; ready at 22
    run_req(1'b0, 3, 23, 1'b0, 0, 0, 0);
    check_bit("t1_up1",   c_up[1],  1'b1);
    check_bit("t1_up4",   c_up[4],  1'b1);
    check_bit("t1_gap5",  c_up[5],  1'b0);
    check_bit("t1_up9",   c_up[9],  1'b1);
    check_bit("t1_up20",  c_up[20], 1'b1);
    check_bit("t1_up21",  c_up[21], 1'b0);
    check_bit("t1_done20", c_done[20], 1'b0);
    check_bit("t1_done21", c_done[21], 1'b1);
    check_bit("t1_rdy21", c_rdy[21], 1'b0);
    check_bit("t1_rdy22", c_rdy[22], 1'b1);
    check_val("t1_rem1",  c_rem[1],  3);
    check_val("t1_rem9",  c_rem[9],  2);
    check_val("t1_rem17", c_rem[17], 1);
    check_val("t1_rem21", c_rem[21], 0);
    any_dn = 0; up_hi = 0;
    for (int k = 1; k <= 23; k++) begin
      if (c_dn[k]) any_dn++;
      if (c_up[k]) up_hi++;
    end
    check_val("t1_no_down", any_dn, 0);
    check_val("t1_up_cycles", up_hi, 12);
    check_val("t1_up_rises", rises(1'b0, 23), 3);

    // DOWN x0: DONE at 1, busy only that cycle
    run_req(1'b1, 0, 3, 1'b0, 0, 0, 0);
    check_bit("t2_done1", c_done[1], 1'b1);
    check_bit("t2_busy1", c_busy[1], 1'b1);
    check_bit("t2_busy2", c_busy[2], 1'b0);
    check_bit("t2_rdy2",  c_rdy[2],  1'b1);
    check_val("t2_pulses", rises(1'b1, 3) + rises(1'b0, 3), 0);

    // DOWN x2 with valid held and count changed to 7 mid-train
    run_req(1'b1, 2, 15, 1'b1, 5, 7, 0);
    check_val("t3_down_rises", rises(1'b1, 14), 2);
    check_bit("t3_done13", c_done[13], 1'b1);
    check_bit("t3_rdy13",  c_rdy[13],  1'b0);
    check_bit("t3_rdy14",  c_rdy[14],  1'b1);
    check_bit("t3_dn15",   c_dn[15],   1'b1);
    check_val("t3_rem15",  c_rem[15],  7);

    // Reset during the second pulse of a 5-pulse train
    run_req(1'b0, 5, 9, 1'b0, 0, 0, 0);
    #3;
    check_bit("t4_up_before", bus.up, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("t4_up",    bus.up,        1'b0);
    check_bit("t4_down",  bus.down,      1'b0);
    check_bit("t4_done",  bus.done,      1'b0);
    check_bit("t4_ready", bus.req_ready, 1'b1);
    check_val("t4_rem",   int'(bus.remaining), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    run_req(1'b0, 1, 8, 1'b0, 0, 0, 0);
    check_val("t4_one_pulse", rises(1'b0, 8), 1);
    check_bit("t4_done5", c_done[5], 1'b1);

`ifdef UPDOWN_PULSE_TX_ABORT_EN
    // Abort sampled at the end of cycle 10 of a 4-pulse train
    run_req(1'b0, 4, 13, 1'b0, 0, 0, 10);
    check_bit("t5_up10",   c_up[10],   1'b1);
    check_bit("t5_up11",   c_up[11],   1'b0);
    check_bit("t5_done11", c_done[11], 1'b1);
    check_val("t5_rem11",  c_rem[11],  3);
    check_val("t5_rem12",  c_rem[12],  3);
    check_bit("t5_rdy12",  c_rdy[12],  1'b1);
`endif

    // Full-width count: exactly 255 DOWN pulses, DONE at 255*P + 254*G + 1
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_dir   = 1'b1;
    bus.req_count = 8'd255;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    dn_r = 0; dn_hi = 0; bad_up = 0; done_at = -1; prev = 1'b0;
    for (int k = 1; k <= 2040; k++) begin
      @(negedge clk);
      if (bus.down && !prev) dn_r++;
      if (bus.down) dn_hi++;
      if (bus.up) bad_up++;
      if (bus.done && done_at < 0) done_at = k;
      prev = bus.down;
      @(posedge clk); #2;
    end
    check_val("t7_rises",  dn_r,    255);
    check_val("t7_high",   dn_hi,   1020);
    check_val("t7_no_up",  bad_up,  0);
    check_val("t7_done_at", done_at, 2037);

    // Randomized traffic against the model
    up_r = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_dir   = 1'($urandom_range(0, 1));
      if (r == 0)      bus.req_count = '0;
      else if (r <= 7) bus.req_count = COUNT_W'($urandom_range(1, 6));
      else             bus.req_count = COUNT_W'($urandom_range(7, 20));
`ifdef UPDOWN_PULSE_TX_ABORT_EN
      abort_s = ($urandom_range(0, 40) == 0);
`endif
      @(posedge clk); #2;
    end
    bus.req_valid = 1'b0;
    abort_s = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #2;

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
